// File: rtl/fft_frame_sequencer_if.sv
// FFT core handshake and bin-stream bundle between the frame sequencer and the FFT core.
interface fft_frame_sequencer_if #(
  parameter int bit_width = 34
);
  logic                        en_FFT;
  logic                        finish_FFT;
  logic                        en_comp;
  logic                        done_all;
  logic signed [bit_width-1:0] Re_in;
  logic signed [bit_width-1:0] Im_in;

  modport master (
    output en_FFT,
    input  finish_FFT, en_comp, done_all, Re_in, Im_in
  );

  modport slave (
    input  en_FFT,
    output finish_FFT, en_comp, done_all, Re_in, Im_in
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// One FFT frame per start edge: pulses en_FFT, times the run in BCD, and tracks the
// peak-magnitude bin of the unloaded stream for the 7-segment display.
module fft_frame_sequencer #(
  parameter int bit_width = 34,
  parameter int N         = 32,
  parameter int SIZE      = 5,
  parameter int TIMEOUT   = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  fft_frame_sequencer_if.master fft,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  done_pulse,
  output logic                  error,
  output logic [15:0]           time_bcd,
  output logic [15:0]           peak_bcd,
  output logic [SIZE-1:0]       peak_idx,
  output logic [16:0]           peak_mag
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, UNLOAD, DONE, ERR} state_t;

  state_t          state;
  logic            start_d;
  logic            en_fft_q;
  logic [TW-1:0]   run_cnt;
  logic [BW-1:0]   bin_cnt;
  logic [15:0]     bin_bcd;

  logic            req;
  logic signed [7:0]  re8, im8;
  logic signed [15:0] re_sq, im_sq;
  logic [16:0]     mag;
  logic            last_bin;

  // Four-digit BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) return v;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    req      = start & ~start_d;
    re8      = fft.Re_in[bit_width-1 -: 8];
    im8      = fft.Im_in[bit_width-1 -: 8];
    re_sq    = re8 * re8;
    im_sq    = im8 * im8;
    mag      = {1'b0, re_sq} + {1'b0, im_sq};
    last_bin = fft.en_comp && (bin_cnt == BW'(N - 1));
  end

  assign fft.en_FFT = en_fft_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_d      <= 1'b0;
      en_fft_q     <= 1'b0;
      run_cnt      <= '0;
      bin_cnt      <= '0;
      bin_bcd      <= '0;
      result_valid <= 1'b0;
      done_pulse   <= 1'b0;
      error        <= 1'b0;
      time_bcd     <= '0;
      peak_bcd     <= '0;
      peak_idx     <= '0;
      peak_mag     <= '0;
    end else begin
      start_d <= start;
      case (state)
        IDLE: begin
          // Frame state is cleared on entry so START already presents the cleared values.
          if (req) begin
            state        <= START;
            en_fft_q     <= 1'b1;
            run_cnt      <= '0;
            bin_cnt      <= '0;
            bin_bcd      <= '0;
            time_bcd     <= '0;
            peak_mag     <= '0;
            peak_idx     <= '0;
            peak_bcd     <= '0;
            error        <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        START: begin
          en_fft_q <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          time_bcd <= bcd_inc(time_bcd);
          run_cnt  <= run_cnt + TW'(1);
          if (fft.finish_FFT) begin
            state <= UNLOAD;
          end else if (run_cnt == TW'(TIMEOUT - 1)) begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        UNLOAD: begin
          if (fft.en_comp) begin
            if (bin_cnt == '0 || mag > peak_mag) begin
              peak_mag <= mag;
              peak_idx <= SIZE'(bin_cnt);
              peak_bcd <= bin_bcd;
            end
            bin_cnt <= bin_cnt + BW'(1);
            bin_bcd <= bcd_inc(bin_bcd);
          end
          if (fft.done_all || last_bin) begin
            state        <= DONE;
            done_pulse   <= 1'b1;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          done_pulse <= 1'b0;
          state      <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences one FFT frame per user request. Issues the en_FFT start pulse and times the transform in BCD cycles. Scans the bin stream for the peak-magnitude bin and publishes time, peak index and peak magnitude to the 7-segment display logic with a valid flag. Sits between the debounced key inputs, the FFT core and seg7 display logic.

Parameters:
bit_width, 34, width of signed Re_in/Im_in bin samples
N, 32, bins per frame; legal range 1..9999
SIZE, 5, width of binary bin index (2^SIZE >= N)
TIMEOUT, 500000, max RUN cycles before error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level request from debounced key; rising edge is a request
en_FFT  out  1  one-cycle FFT start pulse
finish_FFT  in  1  FFT core finished computing
en_comp  in  1  one output bin valid on Re_in/Im_in this cycle
done_all  in  1  FFT core finished unloading bins
Re_in  in  bit_width  signed real part of current bin
Im_in  in  bit_width  signed imaginary part of current bin
busy  out  1  high in every state except IDLE
result_valid  out  1  results below are valid for the last frame
done_pulse  out  1  one-cycle pulse on successful frame completion
error  out  1  sticky timeout flag
time_bcd  out  16  RUN cycle count, 4 BCD digits, digit0 = [3:0]
peak_bcd  out  16  peak bin index, 4 BCD digits
peak_idx  out  SIZE  peak bin index, binary
peak_mag  out  17  peak magnitude, unsigned

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; the start edge register is cleared. Reset mid-frame aborts the frame and never emits en_FFT.
- Request: start_d registered each cycle; req = start & ~start_d. A req outside IDLE is dropped, not queued.
- FSM states are IDLE, START, RUN, UNLOAD, DONE, ERR.
- IDLE -> START on req.
- START, one cycle: en_FFT=1. Clear time counter, bin counter, running max and error. Set result_valid=0. Next state is RUN.
- RUN: time_bcd increments every cycle, including the cycle finish_FFT is seen. It is a BCD ripple counter: each digit wraps 9->0 with carry. It saturates at 9999, with no wrap.
- RUN has a separate binary counter. If it reaches TIMEOUT before finish_FFT, go to ERR. If finish_FFT and timeout occur in the same cycle, finish_FFT wins. On finish_FFT, go to UNLOAD.
- UNLOAD, per en_comp cycle:
  - re8 = Re_in[bit_width-1 -: 8] and im8 = Im_in[bit_width-1 -: 8], both signed.
  - mag = re8*re8 + im8*im8, 17-bit unsigned; maximum is 32768.
  - Bin 0 is always loaded into the max.
  - For later bins, update only if mag > stored max (strict), so the lowest index wins ties.
  - On an update, capture peak_idx and peak_bcd from the bin counter.
  - Then increment the binary and BCD bin counters.
- UNLOAD ends, going to DONE, when the N-th en_comp has been accepted or done_all is high. If done_all coincides with en_comp, that bin is processed first. en_comp in other states is ignored.
- DONE, one cycle: done_pulse=1 and result_valid=1, then go to IDLE. Outputs hold until the next START.
- If done_all arrives with zero bins accepted, result_valid=1 with peak_mag=0 and peak_idx=0.
- ERR, one cycle: error=1 (sticky until next START), result_valid stays 0, then go to IDLE. time_bcd holds the count reached.
- Output latency: peak fields update the cycle after the winning en_comp.

Test Plan:
- Start edge, finish_FFT 37 cycles after en_FFT, 32 bins with bin 5 = (Re top8=10, Im top8=-3), all others 0 -> one en_FFT pulse; time_bcd=0x0037; peak_idx=5; peak_bcd=0x0005; peak_mag=109; done_pulse once; result_valid=1.
- Bins 3 and 9 both magnitude 200, all others smaller -> peak_idx=3 (tie keeps first).
- Bin 0 = (-128,-128) -> peak_mag=32768 with no overflow; hold start high for 100 cycles -> only one frame starts.
- TIMEOUT=20, finish_FFT never asserted -> error=1 after 20 RUN cycles; result_valid=0; busy=0; a next start clears error.
- Second start edge during UNLOAD -> ignored. done_all together with bin 10 (the largest) -> peak_idx=10, DONE.
- rst_n low mid-RUN -> all outputs 0 immediately; after release a start edge runs a clean frame with time counted from 1.
